// File: rtl/demux_collector_pkg.sv
// demux_collector_pkg: shared types and constants for the demux collector.
//   state_t   : collector FSM states (COLLECT gathers lanes, HOLD presents word)
//   LANES     : number of lanes / width of the assembled word
//   SEL_W     : width of the lane select
//   FULL_MASK : fill mask value meaning every lane has been written
package demux_collector_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  localparam int LANES = 4;
  localparam int SEL_W = 2;
  localparam logic [LANES-1:0] FULL_MASK = 4'b1111;

endpackage

// File: rtl/demux_sel_decode.sv
// demux_sel_decode: 2-to-4 one-hot decoder with enable.
//   en     in  1 : decode enable; all outputs low when 0
//   sel    in  2 : lane index
//   onehot out 4 : per-lane write enable, bit n high when en and sel==n
module demux_sel_decode
  import demux_collector_pkg::*;
(
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [LANES-1:0] onehot
);

  // Lane select to one-hot write enable.
  always_comb begin
    onehot = 4'b0000;
    if (en) begin
      case (sel)
        2'd0:    onehot = 4'b0001;
        2'd1:    onehot = 4'b0010;
        2'd2:    onehot = 4'b0100;
        2'd3:    onehot = 4'b1000;
        default: onehot = 4'b0000;
      endcase
    end else begin
      onehot = 4'b0000;
    end
  end

endmodule

// File: rtl/demux_collector.sv
// demux_collector: steers one strobed data bit per cycle into one of four
// lanes and presents the assembled 4-bit word with a valid/ack handshake.
//   CLEAR_ON_ACK  param : 1 clears word on acknowledge, 0 keeps last value
//   clk           in  1 : clock, rising edge
//   rst_n         in  1 : asynchronous active-low reset
//   din           in  1 : data bit to steer
//   sel           in  2 : destination lane
//   flag          in  1 : write strobe
//   word_ack      in  1 : consumer acknowledge
//   word          out 4 : assembled word, bit n = lane n
//   word_valid    out 1 : all lanes filled, word held
//   fill_mask     out 4 : lanes written since last acknowledge
//   err           out 1 : sticky protocol error
// Optional feature macro DEMUX_COLLECTOR_ERR_EN: when defined, err flags
// writes to already-filled lanes and writes dropped in HOLD; otherwise err
// is tied low.
module demux_collector
  import demux_collector_pkg::*;
#(
  parameter bit CLEAR_ON_ACK = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic [SEL_W-1:0] sel,
  input  logic             flag,
  input  logic             word_ack,
  output logic [LANES-1:0] word,
  output logic             word_valid,
  output logic [LANES-1:0] fill_mask,
  output logic             err
);

  state_t           state_r, state_nxt_s;
  logic [LANES-1:0] word_r, word_nxt_s;
  logic [LANES-1:0] mask_r, mask_nxt_s;
  logic             valid_r, valid_nxt_s;
  logic [LANES-1:0] we_s;

  demux_sel_decode u_decode (
    .en     (flag && (state_r == COLLECT)),
    .sel    (sel),
    .onehot (we_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= COLLECT;
      word_r  <= 4'b0000;
      mask_r  <= 4'b0000;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      word_r  <= word_nxt_s;
      mask_r  <= mask_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  // Next-state and next-datapath logic; enables are already gated to COLLECT.
  always_comb begin
    state_nxt_s = state_r;
    word_nxt_s  = word_r;
    mask_nxt_s  = mask_r;
    valid_nxt_s = valid_r;
    case (state_r)
      COLLECT: begin
        word_nxt_s = (word_r & ~we_s) | ({LANES{din}} & we_s);
        mask_nxt_s = mask_r | we_s;
        // COLLECT never holds a full mask, so reaching it implies a write now.
        if (mask_nxt_s == FULL_MASK) begin
          state_nxt_s = HOLD;
          valid_nxt_s = 1'b1;
        end else begin
          state_nxt_s = COLLECT;
          valid_nxt_s = 1'b0;
        end
      end
      HOLD: begin
        if (word_ack) begin
          state_nxt_s = COLLECT;
          valid_nxt_s = 1'b0;
          mask_nxt_s  = 4'b0000;
          if (CLEAR_ON_ACK) begin
            word_nxt_s = 4'b0000;
          end else begin
            word_nxt_s = word_r;
          end
        end else begin
          state_nxt_s = HOLD;
          valid_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = COLLECT;
        word_nxt_s  = 4'b0000;
        mask_nxt_s  = 4'b0000;
        valid_nxt_s = 1'b0;
      end
    endcase
  end

`ifdef DEMUX_COLLECTOR_ERR_EN
  logic err_r, err_nxt_s;

  // Sticky error: overwrite of a filled lane, or any write arriving in HOLD.
  always_comb begin
    err_nxt_s = err_r;
    if (((we_s & mask_r) != 4'b0000) || (flag && (state_r == HOLD))) begin
      err_nxt_s = 1'b1;
    end else begin
      err_nxt_s = err_r;
    end
  end

  // Error register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_nxt_s;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  assign word       = word_r;
  assign fill_mask  = mask_r;
  assign word_valid = valid_r;

endmodule

// File: tb/tb_demux_collector.sv
module tb_demux_collector;

`ifdef DEMUX_COLLECTOR_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       din;
  logic [1:0] sel;
  logic       flag;
  logic       word_ack;
  logic [3:0] word, word_nc;
  logic       word_valid, word_valid_nc;
  logic [3:0] fill_mask, fill_mask_nc;
  logic       err, err_nc;

  int checks = 0;
  int errors = 0;

  demux_collector #(.CLEAR_ON_ACK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .flag(flag),
    .word_ack(word_ack), .word(word), .word_valid(word_valid),
    .fill_mask(fill_mask), .err(err)
  );

  demux_collector #(.CLEAR_ON_ACK(1'b0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .flag(flag),
    .word_ack(word_ack), .word(word_nc), .word_valid(word_valid_nc),
    .fill_mask(fill_mask_nc), .err(err_nc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One write cycle; returns 1 time unit after the capturing edge.
  task automatic do_write(input logic [1:0] lane, input logic d);
    @(negedge clk);
    flag = 1'b1; sel = lane; din = d;
    @(posedge clk); #1;
    flag = 1'b0; din = 1'b0; sel = 2'd0;
  endtask

  task automatic do_ack();
    @(negedge clk);
    word_ack = 1'b1;
    @(posedge clk); #1;
    word_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (word !== 4'b0000) begin errors++; $display("FAIL reset_word got %b exp 0000", word); end
    checks++; if (fill_mask !== 4'b0000) begin errors++; $display("FAIL reset_mask got %b exp 0000", fill_mask); end
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", word_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
  endtask

  task automatic test_basic();
    do_write(2'd0, 1'b1);
    checks++; if (fill_mask !== 4'b0001) begin errors++; $display("FAIL basic_mask1 got %b exp 0001", fill_mask); end
    do_write(2'd1, 1'b0);
    do_write(2'd2, 1'b1);
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL basic_valid3 got %b exp 0", word_valid); end
    do_write(2'd3, 1'b1);
    checks++; if (word !== 4'b1101) begin errors++; $display("FAIL basic_word got %b exp 1101", word); end
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", word_valid); end
    checks++; if (fill_mask !== 4'b1111) begin errors++; $display("FAIL basic_mask got %b exp 1111", fill_mask); end
    do_ack();
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL basic_ack_valid got %b exp 0", word_valid); end
  endtask

  task automatic test_order_ack();
    do_write(2'd3, 1'b0);
    do_write(2'd1, 1'b1);
    do_write(2'd0, 1'b1);
    do_write(2'd2, 1'b0);
    checks++; if (word !== 4'b0011) begin errors++; $display("FAIL order_word got %b exp 0011", word); end
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL order_valid got %b exp 1", word_valid); end
    // Hold for an extra cycle without ack: valid and word must stay.
    @(posedge clk); #1;
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL order_hold_valid got %b exp 1", word_valid); end
    do_ack();
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL order_ack_valid got %b exp 0", word_valid); end
    checks++; if (fill_mask !== 4'b0000) begin errors++; $display("FAIL order_ack_mask got %b exp 0000", fill_mask); end
    checks++; if (word !== 4'b0000) begin errors++; $display("FAIL order_ack_word got %b exp 0000", word); end
    checks++; if (word_nc !== 4'b0011) begin errors++; $display("FAIL order_ack_word_noclear got %b exp 0011", word_nc); end
  endtask

  task automatic test_overwrite();
    do_write(2'd2, 1'b1);
    checks++; if (word !== 4'b0100) begin errors++; $display("FAIL ovw_word1 got %b exp 0100", word); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovw_err1 got %b exp 0", err); end
    do_write(2'd2, 1'b0);
    checks++; if (word !== 4'b0000) begin errors++; $display("FAIL ovw_word2 got %b exp 0000", word); end
    checks++; if (fill_mask !== 4'b0100) begin errors++; $display("FAIL ovw_mask2 got %b exp 0100", fill_mask); end
    checks++; if (err !== ERR_ON) begin errors++; $display("FAIL ovw_err2 got %b exp %b", err, ERR_ON); end
    do_write(2'd0, 1'b1);
    do_write(2'd1, 1'b1);
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL ovw_valid_early got %b exp 0", word_valid); end
    do_write(2'd3, 1'b1);
    checks++; if (word !== 4'b1011) begin errors++; $display("FAIL ovw_word got %b exp 1011", word); end
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL ovw_valid got %b exp 1", word_valid); end
    checks++; if (err !== ERR_ON) begin errors++; $display("FAIL ovw_err_sticky got %b exp %b", err, ERR_ON); end
    do_ack();
  endtask

  task automatic test_async_reset();
    do_write(2'd0, 1'b1);
    do_write(2'd1, 1'b1);
    // Ack in COLLECT has no effect.
    do_ack();
    checks++; if (fill_mask !== 4'b0011) begin errors++; $display("FAIL collect_ack_mask got %b exp 0011", fill_mask); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (word !== 4'b0000) begin errors++; $display("FAIL arst_word got %b exp 0000", word); end
    checks++; if (fill_mask !== 4'b0000) begin errors++; $display("FAIL arst_mask got %b exp 0000", fill_mask); end
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", word_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL arst_err got %b exp 0", err); end
    @(negedge clk);
    rst_n = 1'b1;
    // First edge after release accepts a write.
    do_write(2'd3, 1'b1);
    checks++; if (fill_mask !== 4'b1000) begin errors++; $display("FAIL arst_first_write got %b exp 1000", fill_mask); end
  endtask

  task automatic test_flag_ack_collision();
    do_reset();
    for (int i = 0; i < 4; i++) do_write(i[1:0], 1'b1);
    checks++; if (word !== 4'b1111) begin errors++; $display("FAIL coll_word got %b exp 1111", word); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL coll_err_pre got %b exp 0", err); end
    @(negedge clk);
    flag = 1'b1; sel = 2'd0; din = 1'b0; word_ack = 1'b1;
    @(posedge clk); #1;
    flag = 1'b0; word_ack = 1'b0;
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL coll_valid got %b exp 0", word_valid); end
    checks++; if (fill_mask !== 4'b0000) begin errors++; $display("FAIL coll_mask got %b exp 0000", fill_mask); end
    checks++; if (word_nc !== 4'b1111) begin errors++; $display("FAIL coll_word_noclear got %b exp 1111", word_nc); end
    checks++; if (err !== ERR_ON) begin errors++; $display("FAIL coll_err got %b exp %b", err, ERR_ON); end
    do_write(2'd1, 1'b1);
    checks++; if (fill_mask !== 4'b0010) begin errors++; $display("FAIL coll_collect_mask got %b exp 0010", fill_mask); end
  endtask

  task automatic test_no_clear();
    do_reset();
    do_write(2'd0, 1'b0);
    do_write(2'd1, 1'b1);
    do_write(2'd2, 1'b0);
    do_write(2'd3, 1'b1);
    checks++; if (word_nc !== 4'b1010) begin errors++; $display("FAIL nc_word got %b exp 1010", word_nc); end
    do_ack();
    checks++; if (word_nc !== 4'b1010) begin errors++; $display("FAIL nc_ack_word got %b exp 1010", word_nc); end
    do_write(2'd0, 1'b1);
    checks++; if (word_nc !== 4'b1011) begin errors++; $display("FAIL nc_word_after got %b exp 1011", word_nc); end
    checks++; if (fill_mask_nc !== 4'b0001) begin errors++; $display("FAIL nc_mask got %b exp 0001", fill_mask_nc); end
    checks++; if (word_valid_nc !== 1'b0) begin errors++; $display("FAIL nc_valid got %b exp 0", word_valid_nc); end
    checks++; if (word !== 4'b0001) begin errors++; $display("FAIL clr_word_after got %b exp 0001", word); end
  endtask

  initial begin
    rst_n = 1'b0; din = 1'b0; sel = 2'd0; flag = 1'b0; word_ack = 1'b0;
    test_reset();
    test_basic();
    test_order_ack();
    test_overwrite();
    test_async_reset();
    test_flag_ack_collision();
    test_no_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
